// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the combinational ALU: register file, A/B operand registers,
// B-path shifter and a four-state sequencer that presents operands under valid/ready.
module alu_operand_stage #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(NREGS)-1:0]   rn,
    input  logic [$clog2(NREGS)-1:0]   rm,
    input  logic [1:0]                 shift,
    input  logic [1:0]                 op_in,
    input  logic                       asel,
    input  logic                       bsel,
    input  logic [WIDTH-1:0]           imm,
    input  logic                       write,
    input  logic [$clog2(NREGS)-1:0]   writenum,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       ready,
    output logic [WIDTH-1:0]           val_A,
    output logic [WIDTH-1:0]           val_B,
    output logic [1:0]                 ALU_op,
    output logic                       valid,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RDA     = 2'd1,
        RDB     = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   rn_cap_q, rn_cap_d;
    logic [IDX_W-1:0]   rm_cap_q, rm_cap_d;
    logic [1:0]         shift_cap_q, shift_cap_d;
    logic [1:0]         op_cap_q, op_cap_d;
    logic               asel_cap_q, asel_cap_d;
    logic               bsel_cap_q, bsel_cap_d;
    logic [WIDTH-1:0]   imm_cap_q, imm_cap_d;

    // Fixed-width B shifter; bits shifted out are dropped, there is no carry.
    function automatic logic [WIDTH-1:0] shift_b(input logic [WIDTH-1:0] v,
                                                 input logic [1:0]       s);
        logic signed [WIDTH-1:0] sv;
        sv = signed'(v);
        case (s)
            2'b01:   return {v[WIDTH-2:0], 1'b0};
            2'b10:   return v >> 1;
            2'b11:   return $unsigned(sv >>> 1);
            default: return v;
        endcase
    endfunction

    // Register file: reads anywhere in this module see regs_q, i.e. pre-edge contents.
    always_comb begin
        regs_d = regs_q;
        if (write) begin
            regs_d[writenum] = data_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        rn_cap_d    = rn_cap_q;
        rm_cap_d    = rm_cap_q;
        shift_cap_d = shift_cap_q;
        op_cap_d    = op_cap_q;
        asel_cap_d  = asel_cap_q;
        bsel_cap_d  = bsel_cap_q;
        imm_cap_d   = imm_cap_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rn_cap_d    = rn;
                    rm_cap_d    = rm;
                    shift_cap_d = shift;
                    op_cap_d    = op_in;
                    asel_cap_d  = asel;
                    bsel_cap_d  = bsel;
                    imm_cap_d   = imm;
                    state_d     = RDA;
                end
            end
            RDA: begin
                a_d     = regs_q[rn_cap_q];
                state_d = RDB;
            end
            RDB: begin
                b_d     = shift_b(regs_q[rm_cap_q], shift_cap_q);
                state_d = PRESENT;
            end
            PRESENT: begin
                // A start arriving together with ready is dropped by design.
                if (ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rn_cap_q    <= '0;
            rm_cap_q    <= '0;
            shift_cap_q <= '0;
            op_cap_q    <= '0;
            asel_cap_q  <= 1'b0;
            bsel_cap_q  <= 1'b0;
            imm_cap_q   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rn_cap_q    <= rn_cap_d;
            rm_cap_q    <= rm_cap_d;
            shift_cap_q <= shift_cap_d;
            op_cap_q    <= op_cap_d;
            asel_cap_q  <= asel_cap_d;
            bsel_cap_q  <= bsel_cap_d;
            imm_cap_q   <= imm_cap_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign val_A  = asel_cap_q ? '0 : a_q;
    assign val_B  = bsel_cap_q ? imm_cap_q : b_q;
    assign ALU_op = op_cap_q;
    assign valid  = (state_q == PRESENT);
    assign busy   = (state_q != IDLE);

endmodule
